// File: rtl/dm_access_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : dm_access_pkg                                              |
// | Purpose : Shared encodings for the data-memory access controller:    |
// |           access-size codes, FSM state codes, word-index helper.     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package dm_access_pkg;

   // Access size codes (2'b11 is handled as a word access)
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Controller FSM state codes
   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_rd   = 2'd1;
   localparam logic [1:0] c_st_wr   = 2'd2;

   // Byte address to word index for the word-organised memory
   function automatic logic [31:0] word_index(input logic [31:0] addr);
      return {2'b00, addr[31:2]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/dm_access_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : dm_access_ctrl_if                                        |
// | Purpose   : Request/response handshake from EX/MEM plus the data-    |
// |             memory bus (dmwe/dma/dmwd/dmrd).                         |
// |   master : pipeline + memory side (drives requests and dmrd)         |
// |   slave  : access controller (drives ready, memory bus, results)     |
// | Rev       : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface dm_access_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        dmwe;
   logic [31:0] dma;
   logic [31:0] dmwd;
   logic [31:0] dmrd;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic        misalign;
   logic        addr_err;

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dmrd,
      input  req_ready, dmwe, dma, dmwd, ld_valid, ld_data, misalign, addr_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dmrd,
      output req_ready, dmwe, dma, dmwd, ld_valid, ld_data, misalign, addr_err
   );
endinterface
`default_nettype wire

// File: rtl/dm_access_ctrl_lane_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dm_lane_unit                                               |
// | Purpose : Combinational little-endian lane logic.                    |
// |   old_word  in  32  word read from memory                            |
// |   wdata     in  32  store data (low byte/half for sub-word)          |
// |   size      in   2  access size code                                 |
// |   lane      in   2  byte address bits [1:0]                          |
// |   sign_ext  in   1  sign-extend load result                          |
// |   merged    out 32  old_word with addressed lane replaced            |
// |   extracted out 32  extended load result                             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module dm_lane_unit
   import dm_access_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        sign_ext,
   output logic [31:0] merged,
   output logic [31:0] extracted
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = old_word[7:0];
      case (lane)
         2'd0:    w_byte = old_word[7:0];
         2'd1:    w_byte = old_word[15:8];
         2'd2:    w_byte = old_word[23:16];
         default: w_byte = old_word[31:24];
      endcase
      // Half lane is selected by addr[1] only; odd halves never get here
      w_half = lane[1] ? old_word[31:16] : old_word[15:0];
   end

   always_comb begin
      extracted = old_word;
      case (size)
         SZ_BYTE: extracted = {{24{sign_ext & w_byte[7]}}, w_byte};
         SZ_HALF: extracted = {{16{sign_ext & w_half[15]}}, w_half};
         default: extracted = old_word;
      endcase
   end

   always_comb begin
      merged = old_word;
      case (size)
         SZ_BYTE: begin
            case (lane)
               2'd0:    merged[7:0]   = wdata[7:0];
               2'd1:    merged[15:8]  = wdata[7:0];
               2'd2:    merged[23:16] = wdata[7:0];
               default: merged[31:24] = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            if (lane[1]) merged[31:16] = wdata[15:0];
            else         merged[15:0]  = wdata[15:0];
         end
         default: merged = wdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/dm_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dm_access_ctrl                                             |
// | Purpose : MEM-stage initiator for the word-indexed data memory.      |
// |           Loads take IDLE->RD->IDLE; word stores IDLE->WR; sub-word  |
// |           stores read-modify-write via IDLE->RD->WR.                 |
// |   clk    in  rising-edge clock                                       |
// |   rst_n  in  asynchronous active-low reset                           |
// |   bus    slave modport of dm_access_ctrl_if (request handshake,      |
// |          memory bus, load result and error pulses)                   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module dm_access_ctrl
   import dm_access_pkg::*;
#(
   parameter int DEPTH = 64
)(
   input  logic             clk,
   input  logic             rst_n,
   dm_access_ctrl_if.slave  bus
);

   logic [1:0]  r_state;
   logic        r_dmwe;
   logic [31:0] r_dma;
   logic [31:0] r_dmwd;
   logic        r_ld_valid;
   logic [31:0] r_ld_data;
   logic        r_misalign;
   logic        r_addr_err;
   logic        r_we;
   logic [1:0]  r_size;
   logic [1:0]  r_lane;
   logic        r_signed;
   logic [31:0] r_wdata;

   logic        w_accept;
   logic        w_is_word;
   logic        w_is_half;
   logic        w_misalign;
   logic        w_range_err;
   logic [31:0] w_index;
   logic [31:0] w_merged;
   logic [31:0] w_extracted;

   assign w_accept    = bus.req_valid & (r_state == c_st_idle);
   assign w_is_word   = bus.req_size[1];
   assign w_is_half   = (bus.req_size == SZ_HALF);
   assign w_misalign  = (w_is_half & bus.req_addr[0]) | (w_is_word & (|bus.req_addr[1:0]));
   assign w_index     = word_index(bus.req_addr);
   assign w_range_err = (w_index >= 32'(DEPTH));

   // Lane logic always works on the latched request and the live read data
   dm_lane_unit u_lane (
      .old_word  (bus.dmrd),
      .wdata     (r_wdata),
      .size      (r_size),
      .lane      (r_lane),
      .sign_ext  (r_signed),
      .merged    (w_merged),
      .extracted (w_extracted)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= c_st_idle;
         r_dmwe     <= 1'b0;
         r_dma      <= '0;
         r_dmwd     <= '0;
         r_ld_valid <= 1'b0;
         r_ld_data  <= '0;
         r_misalign <= 1'b0;
         r_addr_err <= 1'b0;
         r_we       <= 1'b0;
         r_size     <= SZ_WORD;
         r_lane     <= 2'd0;
         r_signed   <= 1'b0;
         r_wdata    <= '0;
      end else begin
         // Status outputs are single-cycle pulses
         r_ld_valid <= 1'b0;
         r_misalign <= 1'b0;
         r_addr_err <= 1'b0;
         r_dmwe     <= 1'b0;
         case (r_state)
            c_st_idle: begin
               if (w_accept) begin
                  // Erroring requests leave the memory bus untouched
                  if (w_misalign) begin
                     r_misalign <= 1'b1;
                  end else if (w_range_err) begin
                     r_addr_err <= 1'b1;
                  end else begin
                     r_dma    <= w_index;
                     r_we     <= bus.req_we;
                     r_size   <= bus.req_size;
                     r_lane   <= bus.req_addr[1:0];
                     r_signed <= bus.req_signed;
                     r_wdata  <= bus.req_wdata;
                     if (bus.req_we && w_is_word) begin
                        r_dmwd  <= bus.req_wdata;
                        r_dmwe  <= 1'b1;
                        r_state <= c_st_wr;
                     end else begin
                        r_state <= c_st_rd;
                     end
                  end
               end
            end
            c_st_rd: begin
               if (r_we) begin
                  r_dmwd  <= w_merged;
                  r_dmwe  <= 1'b1;
                  r_state <= c_st_wr;
               end else begin
                  r_ld_data  <= w_extracted;
                  r_ld_valid <= 1'b1;
                  r_state    <= c_st_idle;
               end
            end
            c_st_wr: begin
               r_state <= c_st_idle;
            end
            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   assign bus.req_ready = (r_state == c_st_idle);
   assign bus.dmwe      = r_dmwe;
   assign bus.dma       = r_dma;
   assign bus.dmwd      = r_dmwd;
   assign bus.ld_valid  = r_ld_valid;
   assign bus.ld_data   = r_ld_data;
   assign bus.misalign  = r_misalign;
   assign bus.addr_err  = r_addr_err;

endmodule
`default_nettype wire
